// File: rtl/pc_stack_reg.sv
// rtl/pc_stack_reg.sv - program counter with step, decrement and return-address stack
module pc_stack_reg #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int STEP      = 1,
  parameter int RESET_VAL = 0,
  localparam int SPW      = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  input  logic             err_clr,
  output logic [WIDTH-1:0] value,
  output logic [SPW-1:0]   sp,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);
  localparam logic [SPW-1:0]   DEPTH_SP = SPW'(DEPTH);

  logic [WIDTH-1:0] r_value;
  logic [SPW-1:0]   r_sp;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] r_stack [DEPTH];

  logic             w_full;
  logic             w_empty;
  logic [SPW-1:0]   w_sp_dec;
  logic [AW-1:0]    w_push_idx;
  logic [AW-1:0]    w_pop_idx;
  logic             w_push;

  assign w_full     = (r_sp == DEPTH_SP);
  assign w_empty    = (r_sp == '0);
  assign w_sp_dec   = r_sp - SPW'(1);
  assign w_push_idx = r_sp[AW-1:0];
  assign w_pop_idx  = w_sp_dec[AW-1:0];
  // A push happens only when call wins priority and there is room.
  assign w_push     = !load && call && !w_full;

  assign value     = r_value;
  assign sp        = r_sp;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // Stack storage: plain RAM, contents irrelevant while unoccupied so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= r_value + STEP_W;
    end
  end

  // Counter, stack pointer and sticky flags; one prioritised command per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value     <= RST_W;
      r_sp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // err_clr first so a same-cycle error event below overrides it.
      if (err_clr) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      if (load) begin
        r_value <= data_in;
      end else if (call) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_value <= data_in;
          r_sp    <= r_sp + SPW'(1);
        end
      end else if (ret) begin
        if (w_empty) begin
          r_underflow <= 1'b1;
        end else begin
          r_value <= r_stack[w_pop_idx];
          r_sp    <= w_sp_dec;
        end
      end else if (inc) begin
        r_value <= r_value + STEP_W;
      end else if (dec) begin
        r_value <= r_value - STEP_W;
      end else if (clear) begin
        r_value <= RST_W;
        r_sp    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pc_stack_reg.sv
// tb/tb_pc_stack_reg.sv - randomized and directed checks of pc_stack_reg against a behavioural model
module tb_pc_stack_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       load = 0, call = 0, ret = 0, inc = 0, dec = 0, clear = 0, err_clr = 0;

  logic [7:0] value_a, value_b;
  logic [2:0] sp_a, sp_b;
  logic       full_a, full_b, empty_a, empty_b;
  logic       ovf_a, ovf_b, unf_a, unf_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Model state, index 0 = STEP 1 instance, index 1 = STEP 4 instance
  int m_step [2] = '{1, 4};
  int m_val  [2];
  int m_sp   [2];
  int m_stk  [2][4];
  bit m_ovf  [2];
  bit m_unf  [2];

  always #5 clk = ~clk;

  pc_stack_reg #(.WIDTH(8), .DEPTH(4), .STEP(1), .RESET_VAL(0)) u_dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .call(call), .ret(ret),
    .inc(inc), .dec(dec), .clear(clear), .err_clr(err_clr),
    .value(value_a), .sp(sp_a), .full(full_a), .empty(empty_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  pc_stack_reg #(.WIDTH(8), .DEPTH(4), .STEP(4), .RESET_VAL(0)) u_dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .call(call), .ret(ret),
    .inc(inc), .dec(dec), .clear(clear), .err_clr(err_clr),
    .value(value_b), .sp(sp_b), .full(full_b), .empty(empty_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Literal expectation checked against both the DUT and the model
  task automatic lit(input string nm, input int act, input int mdl, input int exp);
    cmp({nm, " dut"}, act, exp);
    cmp({nm, " model"}, mdl, exp);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0;
      m_sp[k]  = 0;
      m_ovf[k] = 0;
      m_unf[k] = 0;
    end
  endfunction

  function automatic void model_cycle(input bit ld, cl, rt, in, de, clr, ec, input int d);
    for (int k = 0; k < 2; k++) begin
      bit e_ovf = 0;
      bit e_unf = 0;
      if (ld) m_val[k] = d;
      else if (cl) begin
        if (m_sp[k] == 4) e_ovf = 1;
        else begin
          m_stk[k][m_sp[k]] = (m_val[k] + m_step[k]) % 256;
          m_sp[k] = m_sp[k] + 1;
          m_val[k] = d;
        end
      end else if (rt) begin
        if (m_sp[k] == 0) e_unf = 1;
        else begin
          m_sp[k] = m_sp[k] - 1;
          m_val[k] = m_stk[k][m_sp[k]];
        end
      end else if (in) m_val[k] = (m_val[k] + m_step[k]) % 256;
      else if (de) m_val[k] = (m_val[k] + 256 - m_step[k]) % 256;
      else if (clr) begin
        m_val[k] = 0;
        m_sp[k] = 0;
      end
      if (ec) begin
        m_ovf[k] = 0;
        m_unf[k] = 0;
      end
      if (e_ovf) m_ovf[k] = 1;
      if (e_unf) m_unf[k] = 1;
    end
  endfunction

  // Entered at posedge+1; leaves at the following posedge+1 with inputs idle
  task automatic cyc(input bit ld, cl, rt, in, de, clr, ec, input logic [7:0] d);
    load = ld; call = cl; ret = rt; inc = in; dec = de; clear = clr; err_clr = ec; data_in = d;
    @(posedge clk);
    model_cycle(ld, cl, rt, in, de, clr, ec, int'(d));
    #1;
    load = 0; call = 0; ret = 0; inc = 0; dec = 0; clear = 0; err_clr = 0;
  endtask

  // Asynchronous reset asserted mid-cycle, outputs checked before any clock edge
  task automatic do_reset();
    load = 0; call = 0; ret = 0; inc = 0; dec = 0; clear = 0; err_clr = 0;
    #1 reset = 1'b1;
    model_reset();
    #1;
    cmp("rst value", int'(value_a), 0);
    cmp("rst sp", int'(sp_a), 0);
    cmp("rst empty", int'(empty_a), 1);
    cmp("rst ovf", int'(ovf_a), 0);
    cmp("rst unf", int'(unf_a), 0);
    cmp("rst sp b", int'(sp_b), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    model_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
  endtask

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      cmp("a value", int'(value_a), m_val[0]);
      cmp("a sp", int'(sp_a), m_sp[0]);
      cmp("a full", int'(full_a), int'(m_sp[0] == 4));
      cmp("a empty", int'(empty_a), int'(m_sp[0] == 0));
      cmp("a ovf", int'(ovf_a), int'(m_ovf[0]));
      cmp("a unf", int'(unf_a), int'(m_unf[0]));
      cmp("b value", int'(value_b), m_val[1]);
      cmp("b sp", int'(sp_b), m_sp[1]);
      cmp("b full", int'(full_b), int'(m_sp[1] == 4));
      cmp("b empty", int'(empty_b), int'(m_sp[1] == 0));
      cmp("b ovf", int'(ovf_b), int'(m_ovf[1]));
      cmp("b unf", int'(unf_b), int'(m_unf[1]));
    end
  end

  initial begin
    model_reset();
    #2 reset = 1'b0;
    @(posedge clk);
    model_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_en = 1;

    // Reset and basic load/inc
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h20);
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 8'h3C);
    lit("load 3C", int'(value_a), m_val[0], 'h3C);
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
    lit("inc 3D", int'(value_a), m_val[0], 'h3D);

    // Wrap in both directions, and STEP=4 wrap
    cyc(1, 0, 0, 0, 0, 0, 0, 8'hFF);
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
    lit("inc wrap", int'(value_a), m_val[0], 'h00);
    cyc(0, 0, 0, 0, 1, 0, 0, 8'h00);
    lit("dec wrap", int'(value_a), m_val[0], 'hFF);
    cyc(1, 0, 0, 0, 0, 0, 0, 8'hFE);
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
    lit("step4 wrap", int'(value_b), m_val[1], 'h02);

    // Nested calls and returns
    cyc(1, 0, 0, 0, 0, 0, 0, 8'h10);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h40);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h80);
    lit("nest value", int'(value_a), m_val[0], 'h80);
    lit("nest sp", int'(sp_a), m_sp[0], 2);
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h00);
    lit("ret1", int'(value_a), m_val[0], 'h41);
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h00);
    lit("ret2", int'(value_a), m_val[0], 'h11);
    lit("ret2 b", int'(value_b), m_val[1], 'h14);
    cmp("ret2 empty", int'(empty_a), 1);

    // Overflow, underflow and err_clr
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 0, 0, 0, 0, 8'(i));
    cmp("4 calls full", int'(full_a), 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h99);
    lit("ovf value", int'(value_a), m_val[0], 'h04);
    lit("ovf sp", int'(sp_a), m_sp[0], 4);
    lit("ovf flag", int'(ovf_a), int'(m_ovf[0]), 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h00);
    lit("unf value", int'(value_a), m_val[0], 0);
    lit("unf flag", int'(unf_a), int'(m_unf[0]), 1);
    cmp("ovf after clear", int'(ovf_a), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 8'h00);
    cmp("errclr ovf", int'(ovf_a), 0);
    cmp("errclr unf", int'(unf_a), 0);
    cyc(0, 0, 1, 0, 0, 0, 1, 8'h00);
    lit("set wins", int'(unf_a), int'(m_unf[0]), 1);

    // Priority
    cyc(1, 1, 0, 1, 0, 0, 0, 8'h22);
    lit("prio load", int'(value_a), m_val[0], 'h22);
    lit("prio load sp", int'(sp_a), m_sp[0], 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 8'h50);
    lit("prio call", int'(value_a), m_val[0], 'h50);
    lit("prio call sp", int'(sp_a), m_sp[0], 1);
    cyc(0, 0, 0, 1, 1, 1, 0, 8'h00);
    lit("prio inc", int'(value_a), m_val[0], 'h51);
    lit("prio inc sp", int'(sp_a), m_sp[0], 1);

    // Reset with stack occupied
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h60);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h70);
    cmp("pre-rst sp", int'(sp_a), 3);
    do_reset();
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h00);
    lit("post-rst unf", int'(unf_a), int'(m_unf[0]), 1);
    lit("post-rst value", int'(value_a), m_val[0], 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 7) == 0, 8'($urandom));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
